// File: rtl/data_memory_bytelane_if.sv
// Core <-> data memory access bus for the byte-lane data memory.
// Latency: ReadData/Misaligned are combinational from the request; stores land on the next posedge.
// Backpressure: none per access; the core must hold off until Ready=1 (stores before that are dropped).
// Ports: master = core side (drives MemWrite, funct3, ALUResult, WriteData),
//        slave  = memory side (drives ReadData, Ready, Misaligned).
interface data_memory_bytelane_if;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Ready;
  logic        Misaligned;

  modport master (
    output MemWrite, funct3, ALUResult, WriteData,
    input  ReadData, Ready, Misaligned
  );

  modport slave (
    input  MemWrite, funct3, ALUResult, WriteData,
    output ReadData, Ready, Misaligned
  );
endinterface

// File: rtl/data_memory_bytelane.sv
// Byte-lane RV32I data memory (SB/SH/SW, LB/LH/LW/LBU/LHU) with a post-reset clear engine.
// Latency: loads combinational; stores written on posedge; clear takes DEPTH cycles after rst falls.
// Backpressure: Ready=0 during clear; stores are dropped and ReadData/Misaligned read 0 until Ready=1.
// Ports: clk, rst (async active-high), bus (data_memory_bytelane_if.slave).
// Option: define DMEM_MISALIGN_TRAP_EN to flag misaligned accesses, block misaligned stores and
//         zero misaligned loads; otherwise Misaligned=0 and H/W addresses are silently aligned.
module data_memory_bytelane #(
  parameter int DEPTH          = 64,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  data_memory_bytelane_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              ready_q, ready_d;
  logic              clr_we;

  logic [31:0]       mem_q [DEPTH];

  logic [2:0]        f3;
  logic              is_h, is_w;
  logic [1:0]        lo2;        // effective byte offset inside the word
  logic [ADDR_W-1:0] widx;
  logic              blocked;
  logic [31:0]       rd_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_val;
  logic [3:0]        be;
  logic [31:0]       wd_rep;
  logic              st_en;
  logic              unused_addr_hi;

  assign f3   = bus.funct3;
  assign is_h = (f3[1:0] == 2'b01);  // H and HU
  assign is_w = (f3 == 3'b010);
  assign widx = bus.ALUResult[ADDR_W+1:2];
  // Upper address bits are deliberately ignored: the array aliases modulo 4*DEPTH.
  assign unused_addr_hi = ^bus.ALUResult[31:ADDR_W+2];

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_raw;
  assign mis_raw        = (is_h && bus.ALUResult[0]) || (is_w && (bus.ALUResult[1:0] != 2'b00));
  assign lo2            = bus.ALUResult[1:0];
  assign blocked        = mis_raw;
  assign bus.Misaligned = ready_q && mis_raw;
`else
  // Silent alignment: drop the offset bits a halfword/word access cannot use.
  assign lo2            = is_w ? 2'b00 : (is_h ? {bus.ALUResult[1], 1'b0} : bus.ALUResult[1:0]);
  assign blocked        = 1'b0;
  assign bus.Misaligned = 1'b0;
`endif

  // Load path: asynchronous read, lane select, extend.
  assign rd_word = mem_q[widx];
  assign ld_byte = rd_word[{lo2, 3'b000} +: 8];
  assign ld_half = lo2[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_val = '0;
    case (f3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_val = {16'd0, ld_half};
      3'b010:  ld_val = rd_word;
      default: ld_val = '0;
    endcase
  end

  assign bus.ReadData = (ready_q && !blocked) ? ld_val : 32'd0;
  assign bus.Ready    = ready_q;

  // Store path: replicate the low lanes so each enabled lane picks up its own byte.
  always_comb begin
    be     = 4'b0000;
    wd_rep = bus.WriteData;
    case (f3)
      3'b000: begin
        be     = 4'b0001 << lo2;
        wd_rep = {4{bus.WriteData[7:0]}};
      end
      3'b001: begin
        be     = lo2[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{bus.WriteData[15:0]}};
      end
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign st_en = bus.MemWrite && ready_q && !blocked;

  // Clear engine FSM: next state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    clr_we  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        idx_d  = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d = S_RUN;
          ready_d = 1'b1;
        end
      end
      S_RUN:   ready_d = 1'b1;
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (CLEAR_ON_RESET) state_q <= S_CLEAR;
      else                state_q <= S_RUN;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  // The array itself has no reset; the clear engine zeroes it word by word.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[idx_q] <= '0;
    end else if (st_en) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem_q[widx][8*l +: 8] <= wd_rep[8*l +: 8];
      end
    end
  end
endmodule

// File: tb/tb_data_memory_bytelane.sv
module tb_data_memory_bytelane;
  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_memory_bytelane_if bus();

  data_memory_bytelane #(.DEPTH(64), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    string       tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic void add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input logic mis);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd; v.exp_rd = rd; v.exp_mis = mis;
    vecs.push_back(v);
  endfunction

  // Drive one access mid-low-phase, queue its expectation, sample 1ns later.
  // A store's ReadData is the pre-write word; the write lands on the next posedge.
  task automatic apply(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_mis,
                       input string tag);
    exp_t e;
    @(negedge clk);
    bus.MemWrite  = we;
    bus.funct3    = f3;
    bus.ALUResult = addr;
    bus.WriteData = wd;
    e.rd = exp_rd; e.mis = exp_mis; e.tag = tag;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    check32({e.tag, ".rd"}, bus.ReadData, e.rd);
    check32({e.tag, ".mis"}, {31'd0, bus.Misaligned}, {31'd0, e.mis});
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.Ready) break;
    end
  endtask

  initial begin
    int cyc;

    // --- vector table ---
    add(0, F_W,  32'h0000_0000, 32'h0,         32'h0000_0000, 0);
    add(0, F_W,  32'h0000_00FC, 32'h0,         32'h0000_0000, 0);
    add(1, F_W,  32'h0000_0010, 32'h1234_5678, 32'h0000_0000, 0);
    add(0, F_W,  32'h0000_0010, 32'h0,         32'h1234_5678, 0);
    add(0, F_B,  32'h0000_0011, 32'h0,         32'h0000_0056, 0);
    add(0, F_BU, 32'h0000_0013, 32'h0,         32'h0000_0012, 0);
    add(0, F_H,  32'h0000_0012, 32'h0,         32'h0000_1234, 0);
    add(0, F_B,  32'h0000_0010, 32'h0,         32'h0000_0078, 0);
    add(0, F_HU, 32'h0000_0010, 32'h0,         32'h0000_5678, 0);
    add(1, F_W,  32'h0000_0020, 32'h0,         32'h0000_0000, 0);
    add(1, F_B,  32'h0000_0022, 32'h1122_3380, 32'h0000_0000, 0);
    add(0, F_B,  32'h0000_0022, 32'h0,         32'hFFFF_FF80, 0);
    add(0, F_BU, 32'h0000_0022, 32'h0,         32'h0000_0080, 0);
    add(0, F_W,  32'h0000_0020, 32'h0,         32'h0080_0000, 0);
    add(1, F_H,  32'h0000_0022, 32'hCAFE_8001, 32'h0000_0080, 0);
    add(0, F_H,  32'h0000_0022, 32'h0,         32'hFFFF_8001, 0);
    add(0, F_HU, 32'h0000_0022, 32'h0,         32'h0000_8001, 0);
    add(0, F_W,  32'h0000_0020, 32'h0,         32'h8001_0000, 0);
    add(1, F_H,  32'h0000_0020, 32'h0000_BEEF, 32'h0000_0000, 0);
    add(0, F_H,  32'h0000_0020, 32'h0,         32'hFFFF_BEEF, 0);
    add(0, F_W,  32'h0000_0020, 32'h0,         32'h8001_BEEF, 0);
    add(1, 3'b011, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    add(0, F_W,  32'h0000_0020, 32'h0,         32'h8001_BEEF, 0);
    add(1, F_BU, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0000_00EF, 0);
    add(0, F_W,  32'h0000_0020, 32'h0,         32'h8001_BEEF, 0);
    add(0, 3'b110, 32'h0000_0020, 32'h0,       32'h0000_0000, 0);
    add(0, 3'b111, 32'h0000_0020, 32'h0,       32'h0000_0000, 0);
    add(1, F_B,  32'h0000_003F, 32'h0000_007F, 32'h0000_0000, 0);
    add(0, F_W,  32'h0000_003C, 32'h0,         32'h7F00_0000, 0);
    add(0, F_B,  32'h0000_003F, 32'h0,         32'h0000_007F, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    add(1, F_W,  32'h0000_0031, 32'hDEAD_BEEF, 32'h0000_0000, 1);
    add(0, F_W,  32'h0000_0030, 32'h0,         32'h0000_0000, 0);
    add(0, F_W,  32'h0000_0033, 32'h0,         32'h0000_0000, 1);
    add(0, F_H,  32'h0000_0031, 32'h0,         32'h0000_0000, 1);
    add(0, F_B,  32'h0000_0031, 32'h0,         32'h0000_0000, 0);
    add(1, F_H,  32'h0000_0035, 32'h0000_FFFF, 32'h0000_0000, 1);
    add(0, F_W,  32'h0000_0034, 32'h0,         32'h0000_0000, 0);
`else
    add(1, F_W,  32'h0000_0031, 32'hDEAD_BEEF, 32'h0000_0000, 0);
    add(0, F_W,  32'h0000_0030, 32'h0,         32'hDEAD_BEEF, 0);
    add(0, F_W,  32'h0000_0033, 32'h0,         32'hDEAD_BEEF, 0);
    add(0, F_H,  32'h0000_0031, 32'h0,         32'hFFFF_BEEF, 0);
    add(0, F_HU, 32'h0000_0033, 32'h0,         32'h0000_DEAD, 0);
`endif
    add(1, F_W,  32'h0000_0100, 32'hA5A5_A5A5, 32'h0000_0000, 0);
    add(0, F_W,  32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 0);
    add(0, F_W,  32'hFFFF_FF00, 32'h0,         32'hA5A5_A5A5, 0);
    add(0, F_B,  32'h0000_0103, 32'h0,         32'hFFFF_FFA5, 0);

    // --- reset state ---
    rst           = 1'b1;
    bus.MemWrite  = 1'b0;
    bus.funct3    = F_W;
    bus.ALUResult = 32'h0000_0033;
    bus.WriteData = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check32("rst.ready", {31'd0, bus.Ready}, 32'd0);
    check32("rst.rd", bus.ReadData, 32'd0);
    check32("rst.mis", {31'd0, bus.Misaligned}, 32'd0);

    // --- clear length ---
    @(negedge clk);
    rst = 1'b0;
    wait_ready(cyc);
    check32("clear_cycles", cyc, 32'd64);

    // --- table ---
    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].exp_rd, vecs[i].exp_mis,
            $sformatf("v%0d", i));

    // --- reset while running: outputs gate to 0 ---
    @(negedge clk);
    bus.MemWrite  = 1'b0;
    bus.funct3    = F_W;
    bus.ALUResult = 32'h0000_0010;
    rst           = 1'b1;
    #1;
    check32("runrst.ready", {31'd0, bus.Ready}, 32'd0);
    check32("runrst.rd", bus.ReadData, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // --- reset pulse at clear cycle 20, store during clear ignored ---
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check32("midclr.ready", {31'd0, bus.Ready}, 32'd0);
    @(negedge clk);
    rst           = 1'b0;
    bus.MemWrite  = 1'b1;
    bus.funct3    = F_W;
    bus.ALUResult = 32'h0000_0004;
    bus.WriteData = 32'hFFFF_FFFF;
    #1;
    check32("midclr.rd", bus.ReadData, 32'd0);
    wait_ready(cyc);
    bus.MemWrite = 1'b0;
    check32("reclear_cycles", cyc, 32'd64);

    apply(0, F_W, 32'h0000_0004, 32'h0, 32'h0000_0000, 0, "post_clr_04");
    apply(0, F_W, 32'h0000_0010, 32'h0, 32'h0000_0000, 0, "post_clr_10");
    apply(0, F_W, 32'h0000_0000, 32'h0, 32'h0000_0000, 0, "post_clr_00");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
